// File: rtl/s38584_pkg.sv
// s38584_pkg: shared FSM states and per-cone constants for the s38584 scan shuttle
package s38584_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_UNLOAD} state_t;
  localparam int N5101_VEC_W = 27;
  localparam int SETTLE_DEF = 2;
endpackage

// File: rtl/s38584_shift_reg.sv
// s38584_shift_reg: right-shifting register with parallel load; serial bits enter at the MSB
module s38584_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {sin, q[W-1:1]};
endmodule

// File: rtl/s38584_scan_shuttle.sv
// s38584_scan_shuttle: serial load, timed apply, capture and serial unload around one converted s38584 cone
module s38584_scan_shuttle
  import s38584_pkg::*;
#(
  parameter int VEC_W = N5101_VEC_W,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W = 5
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  output logic             busy,
  input  logic             si_valid,
  input  logic             si_data,
  output logic             si_ready,
  output logic [VEC_W-1:0] pi_vec,
  input  logic             po_next,
  output logic             so_valid,
  output logic             so_data,
  input  logic             so_ready,
  output logic             done
);
  state_t state, nxt;
  logic [CNT_W-1:0] bitcnt;
  logic [3:0] setcnt;
  logic [VEC_W-1:0] shadow;
  logic [VEC_W:0] unl;
  logic load_beat, unload_beat, last_load, last_unload, unused_hi;
  assign load_beat = state == S_LOAD && si_valid;
  assign unload_beat = state == S_UNLOAD && so_ready;
  assign last_load = load_beat && bitcnt == CNT_W'(VEC_W - 1);
  assign last_unload = unload_beat && bitcnt == CNT_W'(VEC_W);
  assign busy = state != S_IDLE;
  assign si_ready = state == S_LOAD;
  assign so_valid = state == S_UNLOAD;
  assign so_data = so_valid & unl[0];
  assign unused_hi = ^unl[VEC_W:1];
  // shadow fills LSB-first: each bit enters at the top and settles into place after VEC_W shifts
  s38584_shift_reg #(.W(VEC_W)) u_shadow (
    .clk(CK), .rst(RST), .load(1'b0), .shift(load_beat), .sin(si_data), .d('0), .q(shadow)
  );
  s38584_shift_reg #(.W(VEC_W + 1)) u_unload (
    .clk(CK), .rst(RST), .load(state == S_CAPTURE), .shift(unload_beat), .sin(1'b0),
    .d({shadow, po_next}), .q(unl)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    nxt = start ? S_LOAD : S_IDLE;
      S_LOAD:    nxt = last_load ? S_SETTLE : S_LOAD;
      S_SETTLE:  nxt = setcnt == 4'(SETTLE - 1) ? S_CAPTURE : S_SETTLE;
      S_CAPTURE: nxt = S_UNLOAD;
      S_UNLOAD:  nxt = last_unload ? S_IDLE : S_UNLOAD;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CK)
    if (RST) begin
      state <= S_IDLE;
      bitcnt <= '0;
      setcnt <= '0;
      pi_vec <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= last_unload;
      setcnt <= state == S_SETTLE ? setcnt + 4'd1 : 4'd0;
      bitcnt <= (state == S_IDLE || state == S_CAPTURE || last_load) ? '0 :
                (load_beat || unload_beat) ? bitcnt + CNT_W'(1) : bitcnt;
      // apply the completed vector in one step, including the bit arriving on this beat
      if (last_load) pi_vec <= {si_data, shadow[VEC_W-1:1]};
    end
endmodule

// File: tb/tb_s38584_scan_shuttle.sv
// tb_s38584_scan_shuttle: directed transactions with a queued scoreboard on the serial output
module tb_s38584_scan_shuttle;
  logic CK = 0, RST = 1, RST1 = 1, start = 0, start1 = 0, si_valid = 0, si_data = 0, so_ready = 1;
  logic busy, si_ready, so_valid, so_data, done, po_next;
  logic busy1, si_ready1, so_valid1, so_data1, done1;
  logic [26:0] pi_vec, pi_vec1;
  logic [26:0] prev_vec = '0;
  int pass_cnt = 0, total_cnt = 0, cyc = 0, ndone = 0, ndone1 = 0, exp_done = 0, exp_done1 = 0;
  bit exp_q[$], exp1_q[$];
  bit eb, eb1;

  assign po_next = ^pi_vec;
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  s38584_scan_shuttle #(.VEC_W(27), .SETTLE(2), .CNT_W(5)) dut (
    .CK(CK), .RST(RST), .start(start), .busy(busy), .si_valid(si_valid), .si_data(si_data),
    .si_ready(si_ready), .pi_vec(pi_vec), .po_next(po_next), .so_valid(so_valid),
    .so_data(so_data), .so_ready(so_ready), .done(done)
  );
  s38584_scan_shuttle #(.VEC_W(27), .SETTLE(1), .CNT_W(5)) dut1 (
    .CK(CK), .RST(RST1), .start(start1), .busy(busy1), .si_valid(si_valid), .si_data(si_data),
    .si_ready(si_ready1), .pi_vec(pi_vec1), .po_next(1'b1), .so_valid(so_valid1),
    .so_data(so_data1), .so_ready(so_ready), .done(done1)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act !== want) $display("FAIL %s: got %0h expected %0h", n, act, want);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  always @(negedge CK) begin
    if (so_valid && so_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL so_extra: got beat %0b expected none", so_data);
      end else begin
        eb = exp_q.pop_front();
        chk("so_data", so_data, eb);
      end
    end
    if (so_valid1 && so_ready) begin
      if (exp1_q.size() == 0) begin
        total_cnt++;
        $display("FAIL so1_extra: got beat %0b expected none", so_data1);
      end else begin
        eb1 = exp1_q.pop_front();
        chk("so1_data", so_data1, eb1);
      end
    end
    if (done) ndone++;
    if (done1) ndone1++;
  end

  task automatic xact(input logic [26:0] v, input bit sel, input bit gaps, input int stall_at,
                      input int stall_len, input bit noise, input bit abort, input int exp_lat);
    int t0, guard, s;
    s = sel ? 1 : 2;
    if (!abort) begin
      if (sel) begin
        exp1_q.push_back(1'b1);
        for (int i = 0; i < 27; i++) exp1_q.push_back(v[i]);
      end else begin
        exp_q.push_back(^v);
        for (int i = 0; i < 27; i++) exp_q.push_back(v[i]);
      end
    end
    t0 = cyc;
    if (sel) start1 = 1; else start = 1;
    tick();
    start = 0;
    start1 = 0;
    chk("busy_after_start", sel ? busy1 : busy, 1);
    chk("si_ready_load", sel ? si_ready1 : si_ready, 1);
    for (int i = 0; i < 27; i++) begin
      si_valid = 1;
      si_data = v[i];
      if (i == 26) chk("pi_vec_before_last", sel ? pi_vec1 : pi_vec, prev_vec);
      tick();
      si_valid = 0;
      if (gaps && i < 26) tick();
    end
    chk("pi_vec_applied", sel ? pi_vec1 : pi_vec, v);
    chk("si_ready_settle", sel ? si_ready1 : si_ready, 0);
    if (abort) begin
      RST = 1;
      tick();
      RST = 0;
      chk("abort_busy", busy, 0);
      chk("abort_so_valid", so_valid, 0);
      chk("abort_pi_vec", pi_vec, 0);
      chk("abort_si_ready", si_ready, 0);
      repeat (6) tick();
      chk("abort_no_done", ndone, exp_done);
      chk("abort_idle", busy, 0);
      prev_vec = '0;
      return;
    end
    for (int k = 0; k < s + 1; k++) begin
      if (noise) begin
        si_valid = 1;
        si_data = 1;
      end
      chk("no_early_unload", sel ? so_valid1 : so_valid, 0);
      tick();
    end
    si_valid = 0;
    chk("unload_starts", sel ? so_valid1 : so_valid, 1);
    if (noise) begin
      tick();
      tick();
      start = 1;
      tick();
      start = 0;
    end
    if (stall_len > 0) begin
      repeat (stall_at) tick();
      so_ready = 0;
      repeat (stall_len) begin
        tick();
        chk("stall_hold", so_data, v[stall_at-1]);
        chk("stall_valid", so_valid, 1);
      end
      so_ready = 1;
    end
    guard = 0;
    while (!(sel ? done1 : done) && guard < 300) begin
      tick();
      guard++;
    end
    chk("done_latency", cyc - t0, exp_lat);
    chk("done_busy_low", sel ? busy1 : busy, 0);
    chk("done_so_valid_low", sel ? so_valid1 : so_valid, 0);
    chk("pi_vec_held", sel ? pi_vec1 : pi_vec, v);
    tick();
    if (sel) exp_done1++; else exp_done++;
    chk("done_count", sel ? ndone1 : ndone, sel ? exp_done1 : exp_done);
    chk("done_single", sel ? done1 : done, 0);
    prev_vec = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_si_ready", si_ready, 0);
    chk("reset_so_valid", so_valid, 0);
    chk("reset_so_data", so_data, 0);
    chk("reset_done", done, 0);
    chk("reset_pi_vec", pi_vec, 0);
    chk("reset_pi_vec1", pi_vec1, 0);
    RST = 0;
    tick();
    xact(27'h5A5A5A5, 0, 0, 0, 0, 0, 0, 59);
    xact(27'h4C3B2A1, 0, 0, 10, 5, 0, 0, 64);
    xact(27'h7123456, 0, 1, 0, 0, 0, 0, 85);
    xact(27'h3FFFFFF, 0, 0, 0, 0, 0, 1, 0);
    xact(27'h2AAAAAA, 0, 0, 0, 0, 0, 0, 59);
    xact(27'h1234567, 0, 0, 0, 0, 1, 0, 59);
    RST1 = 0;
    tick();
    prev_vec = '0;
    xact(27'h5A5A5A5, 1, 0, 0, 0, 0, 0, 58);
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("queue1_empty", exp1_q.size(), 0);
    chk("final_done_count", ndone, 5);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/s38584_scan_shuttle.md
Name: s38584_scan_shuttle

Overview:
- Sequential driver/reader for the combinationally converted s38584 partial-output cones.
- Serially loads a present-state/primary-input vector and presents it in parallel to one converted cone for a programmable settle time.
- Captures the cone's single next-state output, then serially unloads the capture bit followed by the applied vector.
- Acts as the state-register end of the cone: it restores the flops the conversion removed, so the cone can be exercised cycle-by-cycle on hardware and in simulation.

Parameters:
- VEC_W, 27, width of vector applied to the cone (27 for the n5101 cone).
- SETTLE, 2, cycles pi_vec is held stable before capture (1..15).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > VEC_W.

Ports:
- CK  input  1  clock, rising edge
- RST  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; begins a load/apply/unload transaction
- busy  output  1  high from accepted start until last unload bit is accepted
- si_valid  input  1  serial-in bit valid
- si_data  input  1  serial-in bit, LSB of vector first
- si_ready  output  1  high only in LOAD
- pi_vec  output  VEC_W  parallel vector driven to the cone inputs
- po_next  input  1  cone output (e.g. n5101)
- so_valid  output  1  serial-out bit valid, high only in UNLOAD
- so_data  output  1  serial-out bit
- so_ready  input  1  downstream accepts so_data
- done  output  1  one-cycle pulse after final unload beat

Behaviour:
- Reset values: all outputs 0; pi_vec = 0; FSM in IDLE; counters 0.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE, UNLOAD.
- IDLE:
  - start=1 moves to LOAD; bit counter cleared; busy=1 from the next cycle.
  - start is ignored in every other state.
- LOAD:
  - si_ready=1.
  - Each beat (si_valid & si_ready) writes si_data into shadow[bitcnt] and increments bitcnt.
  - After beat VEC_W-1, go to SETTLE.
  - No beat means the state holds; there is no timeout.
- Shadow vs applied vector:
  - pi_vec updates only on the LOAD to SETTLE transition, copied whole from the shadow.
  - Partial vectors never reach the cone.
- SETTLE:
  - Counts SETTLE cycles with pi_vec stable, then goes to CAPTURE.
  - SETTLE=1 gives exactly one cycle.
- CAPTURE:
  - Single cycle: cap <= po_next.
  - Builds the unload shift register {shadow, cap}, with cap in the LSB.
  - Goes to UNLOAD; bitcnt cleared.
- UNLOAD:
  - so_valid=1; so_data = shift register LSB.
  - On so_valid & so_ready, shift right and increment bitcnt.
  - After VEC_W+1 beats: done=1 for one cycle, busy=0, return to IDLE.
  - so_ready low stalls indefinitely with so_data held.
- pi_vec stays at the last applied vector after done, until the next SETTLE entry or RST.
- Latency:
  - VEC_W load beats, then SETTLE + 1 cycles, then VEC_W+1 unload beats.
  - With no backpressure and VEC_W=27, SETTLE=2: start to done = 1+27+2+1+28 = 59 cycles.
- Simultaneous start and RST: RST wins.
- RST mid-transaction:
  - Next cycle is IDLE with all outputs 0.
  - pi_vec = 0; the partial shadow is discarded; no done pulse.
- si_valid outside LOAD: ignored (si_ready=0); no state change.

Decomposition:
- Shared package s38584_pkg holds:
  - FSM state enum (IDLE, LOAD, SETTLE, CAPTURE, UNLOAD);
  - VEC_W constants per converted cone (e.g. N5101_VEC_W = 27);
  - the SETTLE default.
- One sub-module: s38584_shift_reg (parallel load, serial in/out, shift enable, width parameter).
  - Instantiated twice: as the load shadow and as the unload register.

Test Plan:
- Basic transaction: VEC_W=27, SETTLE=2, po_next tied to an XOR of pi_vec; load 27'h5A5A5A5 -> pi_vec=27'h5A5A5A5 from cycle 29; first so_data = captured XOR result; then 27 bits 1,0,1,0,... LSB first; done at cycle 59.
- Backpressure: so_ready low for 5 cycles mid-unload at beat 10 -> so_data/so_valid held; done delayed by exactly 5 cycles; bit order intact.
- Load gaps: si_valid deasserted on alternate cycles -> pi_vec unchanged (previous value) until the 27th beat; total load time 53 cycles.
- Reset mid-SETTLE: assert RST for 1 cycle -> next cycle IDLE; pi_vec=0, busy=0, so_valid=0, no done; a new start then completes normally.
- Ignored inputs: start pulsed during UNLOAD and si_valid=1 during SETTLE -> no effect; single done; output stream matches the golden model.
- Boundary SETTLE=1 with po_next=1 -> capture occurs exactly 1 cycle after pi_vec update; first unload bit = 1.
